// File: rtl/maze_pkg.sv
// maze_pkg
// Shared definitions for the maze node probe: default parameter values,
// node classification codes, direction bit positions inside node_dirs,
// the probe FSM state type and the node classification function.

package maze_pkg;

    localparam int PIX_W_DEF    = 8;
    localparam int COORD_W_DEF  = 10;
    localparam int LINE_MAX_DEF = 704;
    localparam int R_DEF        = 8;

    // Bit positions inside node_dirs = {left, down, right, up}
    localparam int DIR_UP    = 0;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 3;

    typedef enum logic [2:0] {
        CLS_WALL     = 3'd0,
        CLS_DEAD_END = 3'd1,
        CLS_STRAIGHT = 3'd2,
        CLS_CORNER   = 3'd3,
        CLS_TEE      = 3'd4,
        CLS_CROSS    = 3'd5,
        CLS_MISS     = 3'd6,
        CLS_ISOLATED = 3'd7
    } node_class_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SCAN  = 2'd2,
        ST_HOLD  = 2'd3
    } probe_state_e;

    // A dark centre is a wall regardless of the arms; otherwise the code is
    // chosen by how many arms are open and, for two arms, whether they face
    // each other (up/down or left/right) or meet at a right angle.
    function automatic node_class_e classify_node(input logic centre,
                                                  input logic [3:0] dirs);
        node_class_e cls;
        cls = CLS_WALL;
        if (centre) begin
            case (dirs)
                4'b0000:                            cls = CLS_ISOLATED;
                4'b0001, 4'b0010, 4'b0100, 4'b1000: cls = CLS_DEAD_END;
                4'b0101, 4'b1010:                   cls = CLS_STRAIGHT;
                4'b0011, 4'b0110, 4'b1100, 4'b1001: cls = CLS_CORNER;
                4'b1111:                            cls = CLS_CROSS;
                default:                            cls = CLS_TEE;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/maze_line_buffer.sv
// maze_line_buffer
// Storage for the previous ROWS binarised video lines, LINE_MAX pixels each.
// Each word holds one pixel column of all ROWS lines, so a single address
// (the horizontal pixel count) reads and writes every stored line at once.
// Read is combinational, write is on the rising clock edge. No reset: a
// location is always written earlier in the frame before its bits are used.
//
// Ports:
//   clk    - clock
//   we     - write enable (one per incoming pixel)
//   addr   - pixel column
//   wdata  - new column contents (bit 0 = most recent line)
//   rdata  - current column contents (bit 0 = most recent line)

module maze_line_buffer #(
    parameter int ROWS     = 16,
    parameter int LINE_MAX = 704,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ROWS-1:0]   wdata,
    output logic [ROWS-1:0]   rdata
);

    localparam int              AW1     = ADDR_W + 1;
    localparam logic [AW1-1:0]  DEPTH_X = AW1'(LINE_MAX);

    logic [ROWS-1:0] mem [LINE_MAX];
    logic            addr_ok;

    // Columns beyond LINE_MAX are neither stored nor returned.
    assign addr_ok = ({1'b0, addr} < DEPTH_X);
    assign rdata   = addr_ok ? mem[addr] : '0;

    always_ff @(posedge clk) begin
        if (we && addr_ok) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/maze_node_probe.sv
// maze_node_probe
// Classifies one maze node in a streamed grey-level video frame. Pixels are
// binarised against a threshold, the last 2R lines are kept in a line buffer
// and a (2R+1)x(2R+1) bit window slides over the image. When the window is
// centred on the requested node, the four arm pixels at distance R and the
// centre pixel are captured and turned into a node class. The video is also
// passed through as a binary overlay with the probe's row/column highlighted.
//
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   video_frame_valid          - high for the whole frame
//   video_line_valid           - high for the whole line
//   video_data_valid           - one pixel per high cycle
//   video_data_in              - grey pixel
//   threshold                  - binarisation level
//   probe_x, probe_y           - node centre to classify
//   probe_load                 - request a probe (ignored while probe_busy)
//   probe_busy                 - a probe is scanning or waiting to be read
//   node_valid / node_ready    - result handshake
//   node_dirs                  - open arms {left,down,right,up}
//   node_class                 - classification code (maze_pkg::node_class_e)
//   video_data_ready           - video_data_out is valid
//   video_data_out             - overlay pixel

module maze_node_probe
    import maze_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int COORD_W  = COORD_W_DEF,
    parameter int LINE_MAX = LINE_MAX_DEF,
    parameter int R        = R_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               video_frame_valid,
    input  logic               video_line_valid,
    input  logic               video_data_valid,
    input  logic [PIX_W-1:0]   video_data_in,
    input  logic [PIX_W-1:0]   threshold,
    input  logic [COORD_W-1:0] probe_x,
    input  logic [COORD_W-1:0] probe_y,
    input  logic               probe_load,
    output logic               probe_busy,
    output logic               node_valid,
    input  logic               node_ready,
    output logic [3:0]         node_dirs,
    output logic [2:0]         node_class,
    output logic               video_data_ready,
    output logic [PIX_W-1:0]   video_data_out
);

    localparam int             WIN      = 2 * R + 1;
    localparam int             LB_ROWS  = 2 * R;
    localparam int             CW1      = COORD_W + 1;
    localparam logic [CW1-1:0] R_X      = CW1'(R);
    localparam logic [CW1-1:0] LINE_MAX_X = CW1'(LINE_MAX);

    logic               frame_d;
    logic               line_d;
    logic               frame_rise;
    logic               frame_fall;
    logic               line_fall;
    logic [COORD_W-1:0] cnt_h;
    logic [COORD_W-1:0] cnt_v;
    logic               bin;

    logic [LB_ROWS-1:0] lb_rdata;
    logic [LB_ROWS-1:0] lb_wdata;
    logic [WIN-1:0]     new_col;
    logic [WIN-1:0]     win [WIN];

    probe_state_e       state;
    probe_state_e       state_next;
    logic [COORD_W-1:0] px;
    logic [COORD_W-1:0] py;
    logic               latch_en;
    logic               capture;
    logic               miss;
    logic               in_range;
    logic               match;
    logic               cap_pending;

    logic [3:0]         arms;
    logic               centre;
    logic [3:0]         dirs_q;
    node_class_e        class_q;
    logic               scanning;
    logic               on_cross;
    logic [PIX_W-1:0]   bin_pixel;

    assign bin = (video_data_in > threshold);

    // Edge detection on the frame and line strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_d <= 1'b0;
            line_d  <= 1'b0;
        end else begin
            frame_d <= video_frame_valid;
            line_d  <= video_line_valid;
        end
    end

    assign frame_rise = video_frame_valid & ~frame_d;
    assign frame_fall = ~video_frame_valid & frame_d;
    assign line_fall  = ~video_line_valid & line_d;

    // cnt_h is the column of the pixel currently on video_data_in and cnt_v
    // its line, both relative to the start of the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (!video_frame_valid) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else begin
            if (line_fall) begin
                cnt_h <= '0;
                cnt_v <= cnt_v + 1'b1;
            end else if (video_data_valid) begin
                cnt_h <= cnt_h + 1'b1;
            end
        end
    end

    maze_line_buffer #(
        .ROWS     (LB_ROWS),
        .LINE_MAX (LINE_MAX),
        .ADDR_W   (COORD_W)
    ) u_line_buffer (
        .clk   (clk),
        .we    (video_data_valid),
        .addr  (cnt_h),
        .wdata (lb_wdata),
        .rdata (lb_rdata)
    );

    // The stored column ages by one line: the new pixel enters at bit 0 and
    // the oldest line drops off the top.
    assign lb_wdata = {lb_rdata[LB_ROWS-2:0], bin};

    // Window row r holds line (cnt_v - 2R + r); the bottom row is the current
    // line, the rows above it come from the line buffer, oldest at row 0.
    always_comb begin
        new_col          = '0;
        new_col[WIN-1]   = bin;
        for (int r = 0; r < LB_ROWS; r++) begin
            new_col[r] = lb_rdata[LB_ROWS-1-r];
        end
    end

    // Window column bit WIN-1 is the newest pixel; columns move toward bit 0
    // as pixels arrive, so bit R of row R is the window centre.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < WIN; r++) begin
                win[r] <= '0;
            end
        end else if (video_data_valid) begin
            for (int r = 0; r < WIN; r++) begin
                win[r] <= {new_col[r], win[r][WIN-1:1]};
            end
        end
    end

    always_comb begin
        arms            = '0;
        arms[DIR_UP]    = win[0][R];
        arms[DIR_RIGHT] = win[R][WIN-1];
        arms[DIR_DOWN]  = win[WIN-1][R];
        arms[DIR_LEFT]  = win[R][0];
        centre          = win[R][R];
    end

    // Probes whose window would reach past the top, left or right image edge
    // never capture; they run to the end of the frame and report a miss.
    assign in_range = ({1'b0, px} >= R_X) &&
                      ({1'b0, py} >= R_X) &&
                      (({1'b0, px} + R_X) < LINE_MAX_X);

    // The bottom-right pixel of the probe's window is arriving now.
    assign match = video_data_valid &&
                   ({1'b0, cnt_h} == ({1'b0, px} + R_X)) &&
                   ({1'b0, cnt_v} == ({1'b0, py} + R_X));

    // The window holds the completed neighbourhood one cycle after the match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_pending <= 1'b0;
        end else begin
            cap_pending <= (state == ST_SCAN) && match && in_range;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A capture on the same cycle as the frame end wins over the miss.
    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        capture    = 1'b0;
        miss       = 1'b0;
        probe_busy = 1'b0;
        node_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (probe_load) begin
                    latch_en   = 1'b1;
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (probe_load) begin
                    latch_en = 1'b1;
                end
                if (frame_rise) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                probe_busy = 1'b1;
                if (cap_pending) begin
                    capture    = 1'b1;
                    state_next = ST_HOLD;
                end else if (frame_fall) begin
                    miss       = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                probe_busy = 1'b1;
                node_valid = 1'b1;
                if (node_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px <= '0;
            py <= '0;
        end else if (latch_en) begin
            px <= probe_x;
            py <= probe_y;
        end
    end

    // The result only changes on leaving SCAN, so it is stable through HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirs_q  <= '0;
            class_q <= CLS_WALL;
        end else if (capture) begin
            dirs_q  <= arms;
            class_q <= classify_node(centre, arms);
        end else if (miss) begin
            dirs_q  <= '0;
            class_q <= CLS_MISS;
        end
    end

    assign node_dirs  = dirs_q;
    assign node_class = class_q;

    assign scanning = (state == ST_SCAN) || (state == ST_HOLD);
    assign on_cross = (cnt_h == px) || (cnt_v == py);

    always_comb begin
        bin_pixel          = '0;
        bin_pixel[PIX_W-1] = bin;
    end

    // Overlay: binary image in the MSB, with the active probe's row and
    // column drawn at full brightness.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            video_data_ready <= 1'b0;
            video_data_out   <= '0;
        end else begin
            video_data_ready <= video_data_valid;
            if (video_data_valid) begin
                video_data_out <= (scanning && on_cross) ? '1 : bin_pixel;
            end
        end
    end

endmodule

// File: tb/tb_maze_node_probe.sv
// tb_maze_node_probe
// Directed bench for maze_node_probe with R=8, threshold=50 and 64x32 frames.
// Each scenario task builds an image, loads a probe, streams a frame and
// compares the captured result, handshake and overlay against values worked
// out by hand from the drawn image.

module tb_maze_node_probe;

    localparam int PIX_W    = 8;
    localparam int COORD_W  = 10;
    localparam int LINE_MAX = 704;
    localparam int R        = 8;
    localparam int FW       = 64;
    localparam int FH       = 32;

    logic               clk;
    logic               reset;
    logic               video_frame_valid;
    logic               video_line_valid;
    logic               video_data_valid;
    logic [PIX_W-1:0]   video_data_in;
    logic [PIX_W-1:0]   threshold;
    logic [COORD_W-1:0] probe_x;
    logic [COORD_W-1:0] probe_y;
    logic               probe_load;
    logic               probe_busy;
    logic               node_valid;
    logic               node_ready;
    logic [3:0]         node_dirs;
    logic [2:0]         node_class;
    logic               video_data_ready;
    logic [PIX_W-1:0]   video_data_out;

    int tests;
    int fails;

    logic [7:0] img     [FH][FW];
    logic [7:0] obs_out [FH][FW];
    logic       obs_rdy [FH][FW];
    logic       obs_gap_rdy [FH];

    logic       seen;
    logic       seen_in_frame;
    logic [3:0] seen_dirs;
    logic [2:0] seen_class;

    maze_node_probe #(
        .PIX_W    (PIX_W),
        .COORD_W  (COORD_W),
        .LINE_MAX (LINE_MAX),
        .R        (R)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .video_frame_valid (video_frame_valid),
        .video_line_valid  (video_line_valid),
        .video_data_valid  (video_data_valid),
        .video_data_in     (video_data_in),
        .threshold         (threshold),
        .probe_x           (probe_x),
        .probe_y           (probe_y),
        .probe_load        (probe_load),
        .probe_busy        (probe_busy),
        .node_valid        (node_valid),
        .node_ready        (node_ready),
        .node_dirs         (node_dirs),
        .node_class        (node_class),
        .video_data_ready  (video_data_ready),
        .video_data_out    (video_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Remember the first cycle node_valid is seen in the current frame.
    task automatic monitor();
        if (node_valid === 1'b1 && !seen) begin
            seen          = 1'b1;
            seen_in_frame = video_frame_valid;
            seen_dirs     = node_dirs;
            seen_class    = node_class;
        end
    endtask

    task automatic step();
        tick();
        monitor();
    endtask

    task automatic clear_img();
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++)
                img[y][x] = 8'd0;
    endtask

    task automatic fill_rect(input int x0, input int x1, input int y0, input int y1,
                             input logic [7:0] v);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                img[y][x] = v;
    endtask

    // 8-pixel corridors centred on x=32 and y=16.
    task automatic draw_vertical();
        fill_rect(28, 35, 0, FH - 1, 8'd200);
    endtask

    task automatic draw_cross();
        draw_vertical();
        fill_rect(0, FW - 1, 12, 19, 8'd200);
    endtask

    task automatic load_probe(input int x, input int y);
        probe_x    = COORD_W'(x);
        probe_y    = COORD_W'(y);
        probe_load = 1'b1;
        step();
        probe_load = 1'b0;
    endtask

    task automatic accept_result();
        node_ready = 1'b1;
        step();
        node_ready = 1'b0;
    endtask

    task automatic send_pixels(input int y, input int x0, input int x1);
        for (int x = x0; x < x1; x++) begin
            video_data_valid = 1'b1;
            video_data_in    = img[y][x];
            step();
            obs_out[y][x] = video_data_out;
            obs_rdy[y][x] = video_data_ready;
        end
    endtask

    task automatic end_line(input int y);
        video_data_valid = 1'b0;
        video_line_valid = 1'b0;
        step();
        obs_gap_rdy[y] = video_data_ready;
        repeat (3) step();
    endtask

    task automatic send_lines(input int y0, input int y1);
        for (int y = y0; y < y1; y++) begin
            video_line_valid = 1'b1;
            step();
            send_pixels(y, 0, FW);
            end_line(y);
        end
    endtask

    task automatic frame_begin();
        seen              = 1'b0;
        video_frame_valid = 1'b1;
        repeat (4) step();
    endtask

    task automatic frame_end();
        video_frame_valid = 1'b0;
        repeat (8) step();
    endtask

    task automatic send_frame();
        frame_begin();
        send_lines(0, FH);
        frame_end();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        tests++;
        if ({node_valid, probe_busy, video_data_ready} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL reset_flags: got valid/busy/ready=%b expected 000",
                     {node_valid, probe_busy, video_data_ready});
        end
        tests++;
        if (video_data_out !== 8'h00) begin
            fails++;
            $display("[TB] FAIL reset_video_out: got %h expected 00", video_data_out);
        end
        tests++;
        if ({node_dirs, node_class} !== 7'd0) begin
            fails++;
            $display("[TB] FAIL reset_result: got dirs=%b class=%0d expected 0000/0",
                     node_dirs, node_class);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cross();
        clear_img();
        draw_cross();
        load_probe(32, 16);
        tests++;
        if (probe_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL armed_busy: got %b expected 0", probe_busy);
        end
        send_frame();
        tests++;
        if (!(seen === 1'b1 && seen_in_frame === 1'b1)) begin
            fails++;
            $display("[TB] FAIL cross_valid_in_frame: got seen=%b in_frame=%b expected 1/1",
                     seen, seen_in_frame);
        end
        tests++;
        if (seen_dirs !== 4'b1111) begin
            fails++;
            $display("[TB] FAIL cross_dirs: got %b expected 1111", seen_dirs);
        end
        tests++;
        if (seen_class !== 3'd5) begin
            fails++;
            $display("[TB] FAIL cross_class: got %0d expected 5", seen_class);
        end
        tests++;
        if ({node_valid, probe_busy} !== 2'b11) begin
            fails++;
            $display("[TB] FAIL cross_held: got valid/busy=%b expected 11",
                     {node_valid, probe_busy});
        end
        accept_result();
        tests++;
        if ({node_valid, probe_busy} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL cross_accept: got valid/busy=%b expected 00",
                     {node_valid, probe_busy});
        end
    endtask

    task automatic test_reset_mid_scan();
        clear_img();
        draw_cross();
        load_probe(32, 16);
        frame_begin();
        send_lines(0, 10);
        video_line_valid = 1'b1;
        step();
        send_pixels(10, 0, 30);
        tests++;
        if ({video_data_ready, video_data_out, probe_busy} !== {1'b1, 8'h80, 1'b1}) begin
            fails++;
            $display("[TB] FAIL pre_reset_state: got ready=%b out=%h busy=%b expected 1/80/1",
                     video_data_ready, video_data_out, probe_busy);
        end
        reset = 1'b1;
        step();
        tests++;
        if ({node_valid, probe_busy, video_data_ready} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL midscan_reset_flags: got valid/busy/ready=%b expected 000",
                     {node_valid, probe_busy, video_data_ready});
        end
        tests++;
        if (video_data_out !== 8'h00) begin
            fails++;
            $display("[TB] FAIL midscan_reset_out: got %h expected 00", video_data_out);
        end
        tests++;
        if ({node_dirs, node_class} !== 7'd0) begin
            fails++;
            $display("[TB] FAIL midscan_reset_result: got dirs=%b class=%0d expected 0000/0",
                     node_dirs, node_class);
        end
        reset = 1'b0;
        send_pixels(10, 30, FW);
        end_line(10);
        send_lines(11, FH);
        frame_end();
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midscan_no_result: got node_valid seen=%b expected 0", seen);
        end
        tests++;
        if (probe_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midscan_idle: got busy=%b expected 0", probe_busy);
        end
    endtask

    task automatic test_straight_hold();
        clear_img();
        draw_vertical();
        load_probe(32, 16);
        send_frame();
        tests++;
        if (!(seen === 1'b1 && seen_in_frame === 1'b1)) begin
            fails++;
            $display("[TB] FAIL straight_valid_in_frame: got seen=%b in_frame=%b expected 1/1",
                     seen, seen_in_frame);
        end
        tests++;
        if (seen_dirs !== 4'b0101) begin
            fails++;
            $display("[TB] FAIL straight_dirs: got %b expected 0101", seen_dirs);
        end
        tests++;
        if (seen_class !== 3'd2) begin
            fails++;
            $display("[TB] FAIL straight_class: got %0d expected 2", seen_class);
        end
        for (int i = 0; i < 100; i++) begin
            step();
            tests++;
            if ({node_valid, probe_busy, node_dirs, node_class} !== {2'b11, 4'b0101, 3'd2}) begin
                fails++;
                $display("[TB] FAIL hold_stable cycle %0d: got valid/busy=%b dirs=%b class=%0d expected 11/0101/2",
                         i, {node_valid, probe_busy}, node_dirs, node_class);
            end
        end
        accept_result();
        tests++;
        if (node_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL straight_accept: got valid=%b expected 0", node_valid);
        end
    endtask

    task automatic test_wall();
        clear_img();
        load_probe(32, 16);
        send_frame();
        tests++;
        if (!(seen === 1'b1 && seen_in_frame === 1'b1)) begin
            fails++;
            $display("[TB] FAIL wall_valid_in_frame: got seen=%b in_frame=%b expected 1/1",
                     seen, seen_in_frame);
        end
        tests++;
        if ({seen_dirs, seen_class} !== {4'b0000, 3'd0}) begin
            fails++;
            $display("[TB] FAIL wall_result: got dirs=%b class=%0d expected 0000/0",
                     seen_dirs, seen_class);
        end
        accept_result();
    endtask

    task automatic test_miss();
        clear_img();
        draw_cross();
        load_probe(4, 16);
        send_frame();
        tests++;
        if (!(seen === 1'b1 && seen_in_frame === 1'b0)) begin
            fails++;
            $display("[TB] FAIL miss_at_frame_end: got seen=%b in_frame=%b expected 1/0",
                     seen, seen_in_frame);
        end
        tests++;
        if ({seen_dirs, seen_class} !== {4'b0000, 3'd6}) begin
            fails++;
            $display("[TB] FAIL miss_result: got dirs=%b class=%0d expected 0000/6",
                     seen_dirs, seen_class);
        end
        accept_result();
    endtask

    task automatic test_reload();
        clear_img();
        draw_cross();
        load_probe(4, 16);
        load_probe(32, 16);
        tests++;
        if (probe_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reload_busy: got %b expected 0", probe_busy);
        end
        send_frame();
        tests++;
        if (!(seen === 1'b1 && seen_in_frame === 1'b1)) begin
            fails++;
            $display("[TB] FAIL reload_valid_in_frame: got seen=%b in_frame=%b expected 1/1",
                     seen, seen_in_frame);
        end
        tests++;
        if ({seen_dirs, seen_class} !== {4'b1111, 3'd5}) begin
            fails++;
            $display("[TB] FAIL reload_result: got dirs=%b class=%0d expected 1111/5",
                     seen_dirs, seen_class);
        end
        accept_result();
    endtask

    task automatic test_overlay();
        logic [7:0] exp;
        clear_img();
        img[5][10]  = 8'd51;
        img[5][11]  = 8'd50;
        img[20][20] = 8'd255;
        load_probe(32, 16);
        send_frame();
        for (int y = 0; y < FH; y++) begin
            for (int x = 0; x < FW; x++) begin
                if (x == 32 || y == 16)
                    exp = 8'hFF;
                else if (img[y][x] > 8'd50)
                    exp = 8'h80;
                else
                    exp = 8'h00;
                tests++;
                if (obs_out[y][x] !== exp || obs_rdy[y][x] !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL overlay (%0d,%0d): got out=%h ready=%b expected %h/1",
                             x, y, obs_out[y][x], obs_rdy[y][x], exp);
                end
            end
            tests++;
            if (obs_gap_rdy[y] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL overlay_gap_ready line %0d: got %b expected 0",
                         y, obs_gap_rdy[y]);
            end
        end
        accept_result();
    endtask

    initial begin
        tests             = 0;
        fails             = 0;
        seen              = 1'b0;
        seen_in_frame     = 1'b0;
        seen_dirs         = 4'd0;
        seen_class        = 3'd0;
        reset             = 1'b0;
        video_frame_valid = 1'b0;
        video_line_valid  = 1'b0;
        video_data_valid  = 1'b0;
        video_data_in     = 8'd0;
        threshold         = 8'd50;
        probe_x           = '0;
        probe_y           = '0;
        probe_load        = 1'b0;
        node_ready        = 1'b0;
        #2;

        test_reset();
        test_cross();
        test_reset_mid_scan();
        test_straight_hold();
        test_wall();
        test_miss();
        test_reload();
        test_overlay();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
